// File: rtl/counter_sequencer_if.sv
// Command, configuration and status bundle for counter_sequencer.
// Master drives commands and config; slave (the sequencer) returns registered status.
interface counter_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) ();
    logic             i_start;
    logic             i_stop;
    logic             i_clear;
    logic             i_oneshot;
    logic [WIDTH-1:0] i_limit;
    logic [PRE_W-1:0] i_prescale;
    logic [WIDTH-1:0] o_count;
    logic             o_busy;
    logic             o_step;
    logic             o_wrap;
    logic             o_done;

    modport master (
        output i_start, i_stop, i_clear, i_oneshot, i_limit, i_prescale,
        input  o_count, o_busy, o_step, o_wrap, o_done
    );

    modport slave (
        input  i_start, i_stop, i_clear, i_oneshot, i_limit, i_prescale,
        output o_count, o_busy, o_step, o_wrap, o_done
    );
endinterface

// File: rtl/counter_sequencer.sv
// Prescaled up-counter with IDLE/RUN/PAUSE control, periodic or one-shot; all outputs registered (1 cycle).
// No backpressure: commands act on the edge they are sampled, priority clear > stop > start.
module counter_sequencer #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    counter_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] div_q, div_d;
    logic             one_q, one_d;
    logic             busy_q;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
            pre_q   <= '0;
            div_q   <= '0;
            one_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            pre_q   <= pre_d;
            div_q   <= div_d;
            one_q   <= one_d;
            busy_q  <= (state_d != IDLE);
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        pre_d   = pre_q;
        div_d   = div_q;
        one_d   = one_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        if (bus.i_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.i_stop && bus.i_start) begin
                        lim_d   = bus.i_limit;
                        div_d   = bus.i_prescale;
                        one_d   = bus.i_oneshot;
                        cnt_d   = '0;
                        pre_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    // A stop on the same edge a step is due swallows that step.
                    if (bus.i_stop) begin
                        state_d = PAUSE;
                    end else if (pre_q == div_q) begin
                        pre_d  = '0;
                        step_d = 1'b1;
                        if (cnt_q != lim_q) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (one_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d  = '0;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!bus.i_stop && bus.i_start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.o_count = cnt_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_step  = step_q;
    assign bus.o_wrap  = wrap_q;
    assign bus.o_done  = done_q;
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and limit width.
REQ-002 SHALL have parameter PRE_W, default 8, prescaler width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port i_start  input  1  start from IDLE, or resume from PAUSE.
REQ-006 SHALL have port i_stop  input  1  pause counting.
REQ-007 SHALL have port i_clear  input  1  abort; zero count and prescaler; return to IDLE.
REQ-008 SHALL have port i_oneshot  input  1  mode: 1 = one-shot, 0 = periodic; sampled on start from IDLE.
REQ-009 SHALL have port i_limit  input  WIDTH  terminal count; sampled on start from IDLE.
REQ-010 SHALL have port i_prescale  input  PRE_W  divider; step period is i_prescale+1 cycles; sampled on start from IDLE.
REQ-011 SHALL have port o_count  output  WIDTH  current count value.
REQ-012 SHALL have port o_busy  output  1  high in RUN and PAUSE.
REQ-013 SHALL have port o_step  output  1  one-cycle pulse on every count step.
REQ-014 SHALL have port o_wrap  output  1  one-cycle pulse when periodic mode wraps limit->0.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse when one-shot completes.

Function
REQ-016 SHALL implement FSM with states IDLE, RUN and PAUSE; all outputs registered.
REQ-017 SHALL apply command priority i_clear > i_stop > i_start when commands coincide in one cycle.
REQ-018 SHALL, in IDLE with i_start, latch i_limit, i_prescale and i_oneshot, set count=0 and prescaler=0, and enter RUN; o_busy high the next cycle.
REQ-019 SHALL, in RUN, increment prescaler each cycle; when prescaler == latched prescale, set prescaler=0 and take a step; otherwise take no step.
REQ-020 SHALL make the first step occur on the (P+1)th rising edge after the start edge (P = latched prescale); P=0 steps every cycle.
REQ-021 SHALL, on a step with count != limit, set count=count+1 and pulse o_step.
REQ-022 SHALL, on a step with count == limit in periodic mode, set count=0 and pulse o_step and o_wrap together; state stays RUN.
REQ-023 SHALL, on a step with count == limit in one-shot mode, hold count, pulse o_step and o_done, and enter IDLE.
REQ-024 SHALL treat limit=0 as: periodic pulses o_wrap on every step with count held at 0; one-shot completes on the first step.
REQ-025 SHALL use modulo-2^WIDTH arithmetic; count never exceeds latched limit; limit = 2^WIDTH-1 wraps to 0.
REQ-026 SHALL, on i_stop in RUN, enter PAUSE, suppress any step due that cycle, and hold count and prescaler.
REQ-027 SHALL, on i_start in PAUSE, resume RUN from the held count and prescaler, without relatching configuration.
REQ-028 SHALL ignore i_start in RUN and i_stop in IDLE or PAUSE.
REQ-029 SHALL, on i_clear in any state, set count=0 and prescaler=0, enter IDLE, and emit no pulse that cycle.
REQ-030 SHALL keep o_count at its last value in IDLE, except after i_clear or reset.
REQ-031 SHALL ignore config inputs except on start from IDLE.

Reset
REQ-032 SHALL, when i_reset is asserted, immediately and asynchronously force state=IDLE, count=0, prescaler=0, latched config=0, and o_count=0, o_busy=0, o_step=0, o_wrap=0, o_done=0.
REQ-033 SHALL, on reset asserted mid-RUN, abort the run and produce no o_done or o_wrap.
REQ-034 SHALL, after reset deasserts, stay in IDLE until i_start.

Verification
REQ-035 SHALL cover: limit=3, prescale=0, periodic, start -> o_count 1,2,3,0,1...; o_wrap coincides with 3->0 transition, every 4 cycles.
REQ-036 SHALL cover: limit=2, prescale=2, one-shot -> steps at edges 3, 6 and 9 after start; o_done at the 9th edge with o_count=2; o_busy low the next cycle.
REQ-037 SHALL cover: stop at count=5 with a step due, wait 10 cycles, start -> count holds 5, no step during pause, resumes 5->6 after the remaining prescale.
REQ-038 SHALL cover: i_clear, i_stop and i_start asserted together in RUN -> IDLE, count=0, no pulses.
REQ-039 SHALL cover: one-shot with limit=0 -> o_done on the first step, o_count=0.
REQ-040 SHALL cover: async i_reset pulse between clock edges mid-RUN at count=7 -> all outputs 0 before the next edge; IDLE after release.
